// File: rtl/buzzer_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_seq_pkg
//  Brief    : Shared constants and FSM encoding for the buzzer note sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package buzzer_seq_pkg;

    // CPU-side register offsets
    localparam logic [31:0] c_reg_ver  = 32'h00;
    localparam logic [31:0] c_reg_ctrl = 32'h04;
    localparam logic [31:0] c_reg_stat = 32'h08;
    localparam logic [31:0] c_reg_tick = 32'h0C;
    localparam logic [31:0] c_reg_gap  = 32'h10;
    localparam logic [31:0] c_reg_note = 32'h14;
    localparam logic [31:0] c_reg_cmd  = 32'h18;

    // Buzzer-side register offsets
    localparam logic [31:0] c_bz_status    = 32'h04;
    localparam logic [31:0] c_bz_divtar    = 32'h08;
    localparam logic [31:0] c_bz_delay_tar = 32'h0C;
    localparam logic [31:0] c_bz_delay_clr = 32'h14;

    localparam logic [31:0] c_version = 32'h0000_0001;

    localparam int c_div_w = 16;
    localparam int c_dur_w = 16;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT_TAR = 4'd1,
        ST_INIT_CLR = 4'd2,
        ST_FETCH    = 4'd3,
        ST_WR_DIV   = 4'd4,
        ST_WR_ON    = 4'd5,
        ST_PLAY     = 4'd6,
        ST_WR_OFF   = 4'd7,
        ST_GAP      = 4'd8,
        ST_STOP     = 4'd9
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/note_table.sv
`default_nettype none
// ============================================================================
//  Module   : note_table
//  Brief    : Append-only note storage with asynchronous indexed read.
//  Revision : 1.0 - initial release
// ============================================================================
module note_table #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_clear,
    input  logic [31:0]              i_push_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
    output logic [31:0]              o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [c_aw:0] r_count;
    logic          w_push_ok;

    assign w_push_ok = i_push && (r_count != c_full);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_count[c_aw-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_push_ok) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];
    assign o_count   = r_count;
    assign o_full    = (r_count == c_full);

endmodule
`default_nettype wire

// File: rtl/buzzer_melody_seq.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_melody_seq
//  Brief    : CPU-loaded note sequencer that masters the buzzer register port.
//  Revision : 1.0 - initial release
// ============================================================================
module buzzer_melody_seq
    import buzzer_seq_pkg::*;
#(
    parameter int ADDRWIDTH = 5,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [31:0]          rdata,
    input  logic                 wr,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [31:0]          wdata,
    output logic                 bz_wr,
    output logic [ADDRWIDTH-1:0] bz_waddr,
    output logic [31:0]          bz_wdata,
    output logic                 done_irq
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    seq_state_e           r_state;
    seq_state_e           w_next;

    logic                 r_run;
    logic                 r_run_q;
    logic                 r_loop;
    logic [31:0]          r_tick;
    logic [15:0]          r_gap;
    logic                 r_done;
    logic                 r_ovf;
    logic [c_cw-1:0]      r_idx;
    logic [c_cw-1:0]      w_idx_next;
    logic [c_div_w-1:0]   r_div;
    logic [c_dur_w-1:0]   r_dur;
    logic [31:0]          r_tick_cnt;
    logic [15:0]          r_unit_cnt;
    logic [31:0]          r_rdata;
    logic                 r_bz_wr;
    logic [ADDRWIDTH-1:0] r_bz_waddr;
    logic [31:0]          r_bz_wdata;
    logic                 r_done_irq;

    logic [31:0]          w_raddr32;
    logic [31:0]          w_waddr32;
    logic                 w_wr_ctrl;
    logic                 w_wr_tick;
    logic                 w_wr_gap;
    logic                 w_wr_note;
    logic                 w_wr_cmd;
    logic                 w_busy;
    logic                 w_run_rise;
    logic                 w_start;
    logic                 w_latch;
    logic                 w_tbl_clear;
    logic [31:0]          w_entry;
    logic [c_dur_w-1:0]   w_entry_dur;
    logic [c_div_w-1:0]   w_entry_div;
    logic [c_cw-1:0]      w_count;
    logic                 w_full;
    logic [31:0]          w_tick_eff;
    logic                 w_timer_last;
    logic                 w_timer_load;
    logic [31:0]          w_stat;
    logic [31:0]          w_rdata;
    logic                 w_bz_wr;
    logic [31:0]          w_bz_addr;
    logic [31:0]          w_bz_data;
    logic                 w_irq;

    // ------------------------------------------------------------------------
    // CPU decode
    // ------------------------------------------------------------------------
    assign w_raddr32 = 32'(raddr);
    assign w_waddr32 = 32'(waddr);
    assign w_wr_ctrl = wr && (w_waddr32 == c_reg_ctrl);
    assign w_wr_tick = wr && (w_waddr32 == c_reg_tick);
    assign w_wr_gap  = wr && (w_waddr32 == c_reg_gap);
    assign w_wr_note = wr && (w_waddr32 == c_reg_note);
    assign w_wr_cmd  = wr && (w_waddr32 == c_reg_cmd);

    assign w_busy      = (r_state != ST_IDLE);
    assign w_run_rise  = r_run && !r_run_q;
    assign w_start     = (r_state == ST_IDLE) && w_run_rise;
    assign w_tbl_clear = w_wr_cmd && wdata[0] && !w_busy;

    note_table #(
        .DEPTH (DEPTH)
    ) u_note_table (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_wr_note),
        .i_clear     (w_tbl_clear),
        .i_push_data (wdata),
        .i_rd_idx    (r_idx[c_aw-1:0]),
        .o_rd_data   (w_entry),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    assign w_entry_div = w_entry[c_div_w-1:0];
    assign w_entry_dur = w_entry[c_div_w +: c_dur_w];

    // ------------------------------------------------------------------------
    // Duration timing: prescaler of max(TICK,1) cycles feeding a unit counter
    // ------------------------------------------------------------------------
    assign w_tick_eff   = (r_tick == 32'd0) ? 32'd1 : r_tick;
    assign w_timer_last = (r_tick_cnt == 32'd0) && (r_unit_cnt == 16'd1);
    assign w_timer_load = ((w_next == ST_PLAY) && (r_state != ST_PLAY)) ||
                          ((w_next == ST_GAP)  && (r_state != ST_GAP));

    // ------------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_latch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_run_rise) begin
                    w_next     = ST_INIT_TAR;
                    w_idx_next = '0;
                end
            end
            ST_INIT_TAR: w_next = r_run ? ST_INIT_CLR : ST_STOP;
            ST_INIT_CLR: w_next = r_run ? ST_FETCH    : ST_STOP;
            ST_FETCH: begin
                if (!r_run) begin
                    w_next = ST_STOP;
                end else if (r_idx == w_count) begin
                    if (r_loop && (w_count != '0)) begin
                        w_idx_next = '0;
                    end else begin
                        w_next = ST_STOP;
                    end
                end else if (w_entry_dur == '0) begin
                    w_idx_next = r_idx + 1'b1;
                end else begin
                    w_latch    = 1'b1;
                    w_idx_next = r_idx + 1'b1;
                    w_next     = ST_WR_DIV;
                end
            end
            ST_WR_DIV: w_next = r_run ? ST_WR_ON : ST_STOP;
            ST_WR_ON:  w_next = r_run ? ST_PLAY  : ST_STOP;
            ST_PLAY: begin
                if (!r_run) begin
                    w_next = ST_STOP;
                end else if (w_timer_last) begin
                    w_next = ST_WR_OFF;
                end
            end
            ST_WR_OFF: begin
                if (!r_run) begin
                    w_next = ST_STOP;
                end else if (r_gap != 16'd0) begin
                    w_next = ST_GAP;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_GAP: begin
                if (!r_run) begin
                    w_next = ST_STOP;
                end else if (w_timer_last) begin
                    w_next = ST_FETCH;
                end
            end
            ST_STOP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Bus writes are launched on entry so they are visible during the state
    // itself; STATUS=1 therefore lands the cycle before PLAY begins.
    always_comb begin
        w_bz_wr   = 1'b0;
        w_bz_addr = 32'd0;
        w_bz_data = 32'd0;
        case (w_next)
            ST_INIT_TAR: begin
                w_bz_wr   = 1'b1;
                w_bz_addr = c_bz_delay_tar;
                w_bz_data = 32'hFFFF_FFFF;
            end
            ST_INIT_CLR: begin
                w_bz_wr   = 1'b1;
                w_bz_addr = c_bz_delay_clr;
                w_bz_data = 32'd1;
            end
            ST_WR_DIV: begin
                w_bz_wr   = 1'b1;
                w_bz_addr = c_bz_divtar;
                w_bz_data = 32'(w_entry_div);
            end
            ST_WR_ON: begin
                w_bz_wr   = 1'b1;
                w_bz_addr = c_bz_status;
                w_bz_data = {31'd0, (r_div != '0)};
            end
            ST_WR_OFF, ST_STOP: begin
                w_bz_wr   = 1'b1;
                w_bz_addr = c_bz_status;
                w_bz_data = 32'd0;
            end
            default: ;
        endcase
    end

    assign w_irq = (w_next == ST_STOP) && (r_state != ST_STOP) && r_run;

    // ------------------------------------------------------------------------
    // State, timers and register file
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_div      <= '0;
            r_dur      <= '0;
            r_tick_cnt <= 32'd0;
            r_unit_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            if (w_latch) begin
                r_div <= w_entry_div;
                r_dur <= w_entry_dur;
            end
            if (w_timer_load) begin
                r_tick_cnt <= w_tick_eff - 32'd1;
                r_unit_cnt <= (w_next == ST_PLAY) ? r_dur : r_gap;
            end else if ((r_state == ST_PLAY) || (r_state == ST_GAP)) begin
                if (r_tick_cnt == 32'd0) begin
                    r_tick_cnt <= w_tick_eff - 32'd1;
                    r_unit_cnt <= r_unit_cnt - 16'd1;
                end else begin
                    r_tick_cnt <= r_tick_cnt - 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_run_q <= 1'b0;
            r_loop  <= 1'b0;
            r_tick  <= 32'd0;
            r_gap   <= 16'd0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_run_q <= r_run;
            if (w_wr_ctrl) begin
                r_run  <= wdata[0];
                r_loop <= wdata[1];
            end
            if (w_wr_tick) r_tick <= wdata;
            if (w_wr_gap)  r_gap  <= wdata[15:0];
            if (w_wr_cmd && wdata[1]) begin
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
            if (w_start)                r_done <= 1'b0;
            if (w_next == ST_STOP)      r_done <= 1'b1;
            if (w_wr_note && w_full)    r_ovf  <= 1'b1;
        end
    end

    always_comb begin
        w_stat              = 32'd0;
        w_stat[0]           = w_busy;
        w_stat[1]           = r_done;
        w_stat[2]           = r_ovf;
        w_stat[8 +: c_cw]   = w_count;
        w_stat[16 +: c_cw]  = r_idx;
    end

    always_comb begin
        case (w_raddr32)
            c_reg_ver:  w_rdata = c_version;
            c_reg_ctrl: w_rdata = {30'd0, r_loop, r_run};
            c_reg_stat: w_rdata = w_stat;
            c_reg_tick: w_rdata = r_tick;
            c_reg_gap:  w_rdata = {16'd0, r_gap};
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= 32'd0;
            r_bz_wr    <= 1'b0;
            r_bz_waddr <= '0;
            r_bz_wdata <= 32'd0;
            r_done_irq <= 1'b0;
        end else begin
            if (rd) r_rdata <= w_rdata;
            r_bz_wr    <= w_bz_wr;
            r_bz_waddr <= w_bz_addr[ADDRWIDTH-1:0];
            r_bz_wdata <= w_bz_data;
            r_done_irq <= w_irq;
        end
    end

    assign rdata    = r_rdata;
    assign bz_wr    = r_bz_wr;
    assign bz_waddr = r_bz_waddr;
    assign bz_wdata = r_bz_wdata;
    assign done_irq = r_done_irq;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_melody_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buzzer_melody_seq
//  Brief    : Self-checking bench; bus-write timeline model vs. DUT trace.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_melody_seq;

    localparam int AW    = 5;
    localparam int DEPTH = 16;

    localparam logic [AW-1:0] c_a_ver  = 5'h00;
    localparam logic [AW-1:0] c_a_ctrl = 5'h04;
    localparam logic [AW-1:0] c_a_stat = 5'h08;
    localparam logic [AW-1:0] c_a_tick = 5'h0C;
    localparam logic [AW-1:0] c_a_gap  = 5'h10;
    localparam logic [AW-1:0] c_a_note = 5'h14;
    localparam logic [AW-1:0] c_a_cmd  = 5'h18;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [31:0]   rdata;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          bz_wr;
    logic [AW-1:0] bz_waddr;
    logic [31:0]   bz_wdata;
    logic          done_irq;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } bz_ev_t;

    bz_ev_t      got_q[$];
    bz_ev_t      exp_q[$];
    int unsigned irq_q[$];
    int unsigned cyc = 0;
    int unsigned wr_cyc;
    int unsigned exp_irq;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] n_dur [8];
    logic [15:0] n_div [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    buzzer_melody_seq #(.ADDRWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .raddr    (raddr),
        .rdata    (rdata),
        .wr       (wr),
        .waddr    (waddr),
        .wdata    (wdata),
        .bz_wr    (bz_wr),
        .bz_waddr (bz_waddr),
        .bz_wdata (bz_wdata),
        .done_irq (done_irq)
    );

    always @(negedge clk) begin
        if (bz_wr)    got_q.push_back({cyc, bz_waddr, bz_wdata});
        if (done_irq) irq_q.push_back(cyc);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; waddr = a; wdata = d; wr_cyc = cyc;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic cpu_rd(input logic [AW-1:0] a, output logic [31:0] d);
        @(negedge clk);
        rd = 1'b1; raddr = a;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    function automatic void push_exp(input int unsigned c, input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({32'(c), a, d});
    endfunction

    // Expected buzzer-write timeline, offsets relative to the DELAY_TAR write.
    function automatic void build_model(input int tick, input int gap, input int n, input int passes);
        int unsigned t, p;
        t = (tick == 0) ? 1 : tick;
        exp_q.delete();
        push_exp(0, 5'h0C, 32'hFFFF_FFFF);
        push_exp(1, 5'h14, 32'd1);
        p = 2;
        for (int ps = 0; ps < passes; ps++) begin
            if (ps > 0) p = p + 1;
            for (int i = 0; i < n; i++) begin
                if (n_dur[i] == 16'd0) begin
                    p = p + 1;
                end else begin
                    push_exp(p + 1, 5'h08, {16'd0, n_div[i]});
                    push_exp(p + 2, 5'h04, (n_div[i] != 16'd0) ? 32'd1 : 32'd0);
                    push_exp(p + 3 + n_dur[i] * t, 5'h04, 32'd0);
                    p = p + 4 + n_dur[i] * t + gap * t;
                end
            end
        end
        push_exp(p + 1, 5'h04, 32'd0);
        exp_irq = p + 1;
    endfunction

    task automatic cmp_events(input string tag, input int lim, input int unsigned base);
        for (int i = 0; i < lim; i++) begin
            if (i < got_q.size() && i < exp_q.size()) begin
                chk_eq($sformatf("%s.ev%0d.cyc", tag, i), got_q[i].cyc - base, exp_q[i].cyc);
                chk_eq($sformatf("%s.ev%0d.addr", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
                chk_eq($sformatf("%s.ev%0d.data", tag, i), got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic load_notes(input int tick, input int gap, input int n, input logic loop);
        cpu_wr(c_a_ctrl, 32'd0);
        cpu_wr(c_a_cmd, 32'd3);
        cpu_wr(c_a_tick, 32'(tick));
        cpu_wr(c_a_gap, 32'(gap));
        for (int i = 0; i < n; i++) cpu_wr(c_a_note, {n_dur[i], n_div[i]});
        got_q.delete();
        irq_q.delete();
        cpu_wr(c_a_ctrl, {30'd0, loop, 1'b1});
    endtask

    task automatic run_play(input string tag, input int tick, input int gap, input int n);
        logic [31:0] st;
        int unsigned base;
        build_model(tick, gap, n, 1);
        load_notes(tick, gap, n, 1'b0);
        repeat (exp_irq + 12) @(negedge clk);
        base = wr_cyc + 2;
        chk_eq({tag, ".nwr"}, got_q.size(), exp_q.size());
        if (got_q.size() > 0) begin
            base = got_q[0].cyc;
            chk_eq({tag, ".lat"}, base - wr_cyc, 32'd2);
        end
        cmp_events(tag, exp_q.size(), base);
        chk_eq({tag, ".nirq"}, irq_q.size(), 32'd1);
        if (irq_q.size() > 0) chk_eq({tag, ".irqcyc"}, irq_q[0] - base, exp_irq);
        cpu_rd(c_a_stat, st);
        chk_eq({tag, ".stat"}, st & 32'h00FF_FF07, {8'd0, 8'(n), 8'(n), 8'h02});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int          n, budget;
        int unsigned base, nbefore;

        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        raddr = '0; waddr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk_eq("rst.rdata", rdata, 32'd0);
        chk_eq("rst.bz_wr", 32'(bz_wr), 32'd0);
        chk_eq("rst.bz_waddr", 32'(bz_waddr), 32'd0);
        chk_eq("rst.bz_wdata", bz_wdata, 32'd0);
        chk_eq("rst.irq", 32'(done_irq), 32'd0);
        cpu_rd(c_a_ver, v);  chk_eq("ver", v, 32'h1);
        cpu_rd(c_a_stat, v); chk_eq("rst.stat", v, 32'h0);
        cpu_rd(5'h1C, v);    chk_eq("unmapped", v, 32'h0);

        // Reference scenario
        n_dur[0] = 16'd3; n_div[0] = 16'd100;
        n_dur[1] = 16'd2; n_div[1] = 16'd0;
        run_play("basic", 4, 1, 2);

        // TICK=0, skipped dur=0 note, rest note
        n_dur[0] = 16'd1; n_div[0] = 16'd77;
        n_dur[1] = 16'd0; n_div[1] = 16'd5;
        n_dur[2] = 16'd2; n_div[2] = 16'd0;
        run_play("tick0", 0, 0, 3);

        // Randomized tables
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                n_dur[i] = 16'($urandom_range(0, 3));
                n_div[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            end
            run_play($sformatf("rnd%0d", it), $urandom_range(0, 3), $urandom_range(0, 2), n);
        end

        // Table overflow
        cpu_wr(c_a_cmd, 32'd3);
        for (int i = 0; i <= DEPTH; i++) cpu_wr(c_a_note, 32'h0001_0000 + 32'(i));
        cpu_rd(c_a_stat, v);
        chk_eq("ovf.count", 32'(v[15:8]), 32'(DEPTH));
        chk_eq("ovf.flag", 32'(v[2]), 32'd1);
        cpu_wr(c_a_cmd, 32'd2);
        cpu_rd(c_a_stat, v);
        chk_eq("ovf.clr", 32'(v[2]), 32'd0);
        chk_eq("ovf.keep", 32'(v[15:8]), 32'(DEPTH));

        // Looping, then abort during PLAY
        n_dur[0] = 16'd2; n_div[0] = 16'd50;
        n_dur[1] = 16'd1; n_div[1] = 16'd60;
        build_model(2, 0, 2, 2);
        load_notes(2, 0, 2, 1'b1);
        budget = 0;
        while (got_q.size() < 10 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        chk_eq("loop.reach", 32'(got_q.size() >= 10), 32'd1);
        base = (got_q.size() > 0) ? got_q[0].cyc : 0;
        cmp_events("loop", 10, base);
        cpu_wr(c_a_ctrl, 32'd2);
        repeat (10) @(negedge clk);
        chk_eq("abort.nwr", got_q.size(), 32'd11);
        if (got_q.size() == 11) begin
            chk_eq("abort.cyc", got_q[10].cyc - wr_cyc, 32'd2);
            chk_eq("abort.addr", 32'(got_q[10].addr), 32'h04);
            chk_eq("abort.data", got_q[10].data, 32'd0);
        end
        chk_eq("abort.nirq", irq_q.size(), 32'd0);
        cpu_rd(c_a_stat, v);
        chk_eq("abort.stat", v & 32'h00FF_FF07, 32'h0001_0202);

        // Reset during PLAY
        n_dur[0] = 16'd5; n_div[0] = 16'd300;
        load_notes(10, 0, 1, 1'b0);
        budget = 0;
        while (got_q.size() < 4 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        nbefore = got_q.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("mrst.bz_wr", 32'(bz_wr), 32'd0);
        chk_eq("mrst.irq", 32'(done_irq), 32'd0);
        chk_eq("mrst.rdata", rdata, 32'd0);
        cpu_rd(c_a_stat, v); chk_eq("mrst.stat", v, 32'd0);
        cpu_rd(c_a_tick, v); chk_eq("mrst.tick", v, 32'd0);
        repeat (20) @(negedge clk);
        chk_eq("mrst.nowr", got_q.size(), nbefore);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
